// File: rtl/sprite_line_eval.sv
`timescale 1ns/1ps
// Per-scanline sprite evaluator: scans sprite RAM, copies up to MAX_PER_LINE covering sprites into the line buffer.
// Define SPRITE_EVAL_EARLY_EXIT_EN to stop the scan at the first over-limit hit.
module sprite_line_eval #(
  parameter int unsigned SPRITE_NUM   = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned SPRITE_H     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [7:0]                      line_y,
  output logic [$clog2(SPRITE_NUM)-1:0]   ram_addr,
  input  logic [31:0]                     ram_data,
  output logic                            slot_we,
  output logic [$clog2(MAX_PER_LINE)-1:0] slot_idx,
  output logic [31:0]                     slot_data,
  output logic [$clog2(MAX_PER_LINE):0]   slot_count,
  output logic                            overflow,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned AW = $clog2(SPRITE_NUM);
  localparam int unsigned IW = $clog2(MAX_PER_LINE);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      line_q, line_d;
  logic            dv_q, dv_d;
  logic            we_q, we_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [8:0]      diff;
  logic            hit;

  // dv_q marks cycles in which ram_data belongs to an issued, non-discarded address
  assign diff = {1'b0, line_q} - {1'b0, ram_data[23:16]};
  assign hit  = dv_q && !diff[8] && (diff < 9'(SPRITE_H));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    dv_d    = 1'b0;
    we_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
          line_d  = line_y;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SCAN: begin
        dv_d = 1'b1;
        if (addr_q == AW'(SPRITE_NUM - 1)) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (!dv_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Hit handling overrides the sequencing above when an early exit fires
    if (hit) begin
      if (cnt_q < CW'(MAX_PER_LINE)) begin
        we_d   = 1'b1;
        idx_d  = cnt_q[IW-1:0];
        data_d = ram_data;
        cnt_d  = cnt_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef SPRITE_EVAL_EARLY_EXIT_EN
        if (!ovf_q) begin
          state_d = S_DRAIN;
          addr_d  = addr_q;
          dv_d    = 1'b0;
        end
`else
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      dv_q    <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      dv_q    <= dv_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_addr   = addr_q;
  assign slot_we    = we_q;
  assign slot_idx   = idx_q;
  assign slot_data  = data_q;
  assign slot_count = cnt_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_line_eval.sv
`timescale 1ns/1ps
// Self-checking bench for sprite_line_eval: directed and random scans against a list-based reference model.
module tb_sprite_line_eval;

  localparam int N = 64;
  localparam int M = 8;
  localparam int H = 16;
`ifdef SPRITE_EVAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  line_y;
  logic [5:0]  ram_addr;
  logic [31:0] ram_data;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [31:0] slot_data;
  logic [3:0]  slot_count;
  logic        overflow;
  logic        busy;
  logic        done;

  logic [31:0] mem [N];
  int vec = 0;
  int bad = 0;

  sprite_line_eval #(.SPRITE_NUM(N), .MAX_PER_LINE(M), .SPRITE_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .line_y(line_y),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_data(slot_data),
    .slot_count(slot_count), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read sprite RAM
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_busy", i, 64'(busy), 64'(0));
      check("idle_done", i, 64'(done), 64'(0));
      check("idle_we", i, 64'(slot_we), 64'(0));
    end
  endtask

  function automatic bit covers(input logic [7:0] ly, input logic [7:0] py);
    return (int'(ly) >= int'(py)) && (int'(ly) - int'(py) < H);
  endfunction

  // Caller is at the start of cycle 0; start is raised here and the task returns in the done cycle
  task automatic run_scan(input logic [7:0] ly, input int inject_at, input int rst_at);
    int hits[$];
    int n, exp_done, addr_last, last_c, wcnt, ws;
    bit aborted, exp_we, exp_ovf, exp_busy;
    hits = {};
    for (int i = 0; i < N; i++)
      if (covers(ly, mem[i][23:16])) hits.push_back(i);
    n = hits.size();
    exp_done  = (EARLY && n > M) ? hits[M] + 4 : N + 3;
    addr_last = (EARLY && n > M) ? hits[M] + 2 : N;
    last_c    = (rst_at >= 0) ? N + 16 : exp_done;
    line_y = ly;
    start  = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      step();
      start = 1'b0;
      rst   = 1'b0;
      if (c == inject_at) begin start = 1'b1; line_y = ~ly; end
      if (c == rst_at) rst = 1'b1;
      aborted = (rst_at >= 0) && (c > rst_at);
      exp_we = 1'b0; ws = 0; wcnt = 0;
      for (int s = 0; s < n && s < M; s++) begin
        if (hits[s] + 3 <= c) wcnt++;
        if (hits[s] + 3 == c) begin exp_we = 1'b1; ws = s; end
      end
      exp_ovf  = (n > M) && (c >= hits[M] + 3);
      exp_busy = (c < exp_done);
      if (aborted) begin exp_we = 1'b0; wcnt = 0; exp_ovf = 1'b0; exp_busy = 1'b0; end
      check("slot_we", c, 64'(slot_we), 64'(exp_we));
      check("slot_count", c, 64'(slot_count), 64'(wcnt));
      check("overflow", c, 64'(overflow), 64'(exp_ovf));
      check("busy", c, 64'(busy), 64'(exp_busy));
      check("done", c, 64'(done), 64'(!aborted && c == exp_done));
      if (exp_we) begin
        check("slot_idx", c, 64'(slot_idx), 64'(ws));
        check("slot_data", c, 64'(slot_data), 64'(mem[hits[ws]]));
      end
      if (!aborted && c <= addr_last) check("ram_addr", c, 64'(ram_addr), 64'(c - 1));
      if (aborted && c == rst_at + 1) check("ram_addr_rst", c, 64'(ram_addr), 64'(0));
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic fill_posy(input logic [7:0] py);
    for (int i = 0; i < N; i++) mem[i] = {8'($urandom), py, 16'($urandom)};
  endtask

  task automatic set_posy(input int i, input logic [7:0] py);
    mem[i][23:16] = py;
  endtask

  initial begin
    logic [7:0] ly;
    rst = 1'b1; start = 1'b0; line_y = 8'd0;
    fill_posy(8'd0);
    step(); step(); step();
    check("rst_addr", 0, 64'(ram_addr), 64'(0));
    check("rst_we", 0, 64'(slot_we), 64'(0));
    check("rst_idx", 0, 64'(slot_idx), 64'(0));
    check("rst_data", 0, 64'(slot_data), 64'(0));
    check("rst_count", 0, 64'(slot_count), 64'(0));
    check("rst_ovf", 0, 64'(overflow), 64'(0));
    check("rst_busy", 0, 64'(busy), 64'(0));
    check("rst_done", 0, 64'(done), 64'(0));
    rst = 1'b0;
    idle(2);

    // No hits
    fill_posy(8'd200);
    run_scan(8'd10, -1, -1);
    idle(3);

    // Three hits at sprites 5, 20, 63
    fill_posy(8'd0);
    set_posy(5, 8'd100); set_posy(20, 8'd100); set_posy(63, 8'd100);
    run_scan(8'd110, -1, -1);
    idle(3);

    // Vertical extent boundaries and no wrap-around
    fill_posy(8'd200);
    set_posy(0, 8'd100);
    run_scan(8'd115, -1, -1);
    idle(2);
    run_scan(8'd116, -1, -1);
    idle(2);
    set_posy(0, 8'd250);
    run_scan(8'd3, -1, -1);
    idle(2);

    // Overflow, ignored start mid-scan, then back-to-back start in the done cycle
    fill_posy(8'd0);
    for (int i = 0; i < 10; i++) set_posy(i, 8'd100);
    run_scan(8'd105, -1, -1);
    idle(2);
    run_scan(8'd105, 30, -1);
    run_scan(8'd200, -1, -1);
    idle(3);

    // Reset mid-scan after two hits, then a normal scan
    fill_posy(8'd200);
    set_posy(3, 8'd45); set_posy(10, 8'd45); set_posy(40, 8'd45);
    run_scan(8'd50, -1, 20);
    idle(2);
    run_scan(8'd50, -1, -1);
    idle(2);

    // Random scans, some chained back-to-back
    for (int t = 0; t < 12; t++) begin
      ly = 8'($urandom);
      for (int i = 0; i < N; i++)
        mem[i] = {8'($urandom), 8'(ly - 8'($urandom_range(0, 40))), 16'($urandom)};
      run_scan(ly, ((t % 3) == 0) ? int'($urandom_range(1, 60)) : -1, -1);
      if ((t % 2) == 0) idle(int'($urandom_range(1, 4)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
